// File: rtl/variable_latency_bank_adapter.sv
// rtl/variable_latency_bank_adapter.sv - valid/ready request to fixed-latency SRAM bank adapter with credit-protected response FIFO
// Optional feature macro: VARIABLE_LATENCY_BANK_ADAPTER_WRITE_RESP_EN (writes consume a credit and return a zero-data response)
module variable_latency_bank_adapter #(
   parameter int unsigned NumInLog2     = 5,
   parameter int unsigned AddrMemWidth  = 12,
   parameter int unsigned DataWidth     = 32,
   parameter int unsigned BeWidth       = DataWidth / 8,
   parameter int unsigned MemLatency    = 1,
   parameter int unsigned RespFifoDepth = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    req_valid_i,
   output logic                    req_ready_o,
   input  logic [NumInLog2-1:0]    req_ini_addr_i,
   input  logic [AddrMemWidth-1:0] req_tgt_addr_i,
   input  logic                    req_wen_i,
   input  logic [DataWidth-1:0]    req_wdata_i,
   input  logic [BeWidth-1:0]      req_be_i,
   output logic                    resp_valid_o,
   input  logic                    resp_ready_i,
   output logic [NumInLog2-1:0]    resp_ini_addr_o,
   output logic [DataWidth-1:0]    resp_rdata_o,
   output logic                    mem_req_o,
   output logic [AddrMemWidth-1:0] mem_addr_o,
   output logic                    mem_wen_o,
   output logic [DataWidth-1:0]    mem_wdata_o,
   output logic [BeWidth-1:0]      mem_be_o,
   input  logic [DataWidth-1:0]    mem_rdata_i
);

   if (MemLatency < 1) begin : g_bad_latency
      $fatal(1, "MemLatency must be >= 1");
   end
   if (RespFifoDepth < 1) begin : g_bad_depth
      $fatal(1, "RespFifoDepth must be >= 1");
   end

   localparam int unsigned CntW = $clog2(RespFifoDepth + 1);
   localparam int unsigned PtrW = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;
   localparam int unsigned EntW = NumInLog2 + DataWidth;
   localparam logic [CntW-1:0] DepthC   = CntW'(RespFifoDepth);
   localparam logic [PtrW-1:0] LastPtrC = PtrW'(RespFifoDepth - 1);

   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [CntW-1:0]      occ_q, occ_d;
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [EntW-1:0]      fifo_q [RespFifoDepth];
   logic [EntW-1:0]      fifo_d [RespFifoDepth];
   logic                 pipe_vld_q  [MemLatency];
   logic                 pipe_vld_d  [MemLatency];
   logic                 pipe_zero_q [MemLatency];
   logic                 pipe_zero_d [MemLatency];
   logic [NumInLog2-1:0] pipe_ini_q  [MemLatency];
   logic [NumInLog2-1:0] pipe_ini_d  [MemLatency];

   logic                 needs_credit;
   logic                 fire;
   logic                 take_credit;
   logic                 push;
   logic                 pop;
   logic [DataWidth-1:0] push_data;
   logic [EntW-1:0]      head;

`ifdef VARIABLE_LATENCY_BANK_ADAPTER_WRITE_RESP_EN
   assign needs_credit = 1'b1;
`else
   assign needs_credit = !req_wen_i;
`endif

   // Credits cover every in-flight response, so acceptance never looks at resp_ready_i.
   assign req_ready_o = rst_ni & (!needs_credit | (cnt_q < DepthC));
   assign fire        = req_valid_i & req_ready_o;
   assign take_credit = fire & needs_credit;

   assign mem_req_o   = fire;
   assign mem_addr_o  = fire ? req_tgt_addr_i : '0;
   assign mem_wen_o   = fire & req_wen_i;
   assign mem_wdata_o = fire ? req_wdata_i : '0;
   assign mem_be_o    = fire ? req_be_i : '0;

   assign push      = pipe_vld_q[MemLatency-1];
   assign push_data = pipe_zero_q[MemLatency-1] ? '0 : mem_rdata_i;

   assign head            = fifo_q[rd_ptr_q];
   assign resp_valid_o    = (occ_q != '0);
   assign pop             = resp_valid_o & resp_ready_i;
   assign resp_ini_addr_o = resp_valid_o ? head[EntW-1:DataWidth] : '0;
   assign resp_rdata_o    = resp_valid_o ? head[DataWidth-1:0] : '0;

   // Tag pipeline tracks which bank accesses will produce a response and when.
   always_comb begin
      pipe_vld_d[0]  = take_credit;
      pipe_zero_d[0] = req_wen_i;
      pipe_ini_d[0]  = req_ini_addr_i;
      for (int unsigned i = 1; i < MemLatency; i++) begin
         pipe_vld_d[i]  = pipe_vld_q[i-1];
         pipe_zero_d[i] = pipe_zero_q[i-1];
         pipe_ini_d[i]  = pipe_ini_q[i-1];
      end
   end

   // Credit counter, FIFO occupancy, storage and wrapping pointers.
   always_comb begin
      cnt_d = cnt_q;
      if (take_credit && !pop) begin
         cnt_d = cnt_q + CntW'(1);
      end else if (!take_credit && pop) begin
         cnt_d = cnt_q - CntW'(1);
      end
      occ_d = occ_q;
      if (push && !pop) begin
         occ_d = occ_q + CntW'(1);
      end else if (!push && pop) begin
         occ_d = occ_q - CntW'(1);
      end
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         fifo_d[wr_ptr_q] = {pipe_ini_q[MemLatency-1], push_data};
         wr_ptr_d = (wr_ptr_q == LastPtrC) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == LastPtrC) ? '0 : rd_ptr_q + PtrW'(1);
      end
   end

   // State registers; reset discards in-flight and buffered responses.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int unsigned i = 0; i < RespFifoDepth; i++) begin
            fifo_q[i] <= '0;
         end
         for (int unsigned i = 0; i < MemLatency; i++) begin
            pipe_vld_q[i]  <= 1'b0;
            pipe_zero_q[i] <= 1'b0;
            pipe_ini_q[i]  <= '0;
         end
      end else begin
         cnt_q       <= cnt_d;
         occ_q       <= occ_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fifo_q      <= fifo_d;
         pipe_vld_q  <= pipe_vld_d;
         pipe_zero_q <= pipe_zero_d;
         pipe_ini_q  <= pipe_ini_d;
      end
   end

endmodule

// File: tb/tb_variable_latency_bank_adapter.sv
// tb/tb_variable_latency_bank_adapter.sv - self-checking bench for variable_latency_bank_adapter
module tb_variable_latency_bank_adapter;

   localparam int LatB   = 3;
   localparam int DepthB = 5;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_bad;

   // Instance A: MemLatency=1, RespFifoDepth=3
   logic        a_vld, a_rdy, a_wen, a_rv, a_rr, a_mreq, a_mwen;
   logic [4:0]  a_ini, a_rini;
   logic [11:0] a_addr, a_maddr;
   logic [31:0] a_wdata, a_rdata, a_mwdata, a_mrdata;
   logic [3:0]  a_be, a_mbe;

   // Instance B: MemLatency=3, RespFifoDepth=5
   logic        b_vld, b_rdy, b_wen, b_rv, b_rr, b_mreq, b_mwen;
   logic [4:0]  b_ini, b_rini;
   logic [11:0] b_addr, b_maddr;
   logic [31:0] b_wdata, b_rdata, b_mwdata, b_mrdata;
   logic [3:0]  b_be, b_mbe;

   logic [31:0] sram_a [4096];
   logic [31:0] sram_b [4096];
   logic [31:0] model_b [4096];
   logic [31:0] rb [LatB];

   typedef struct {
      logic vld; logic wen; logic [11:0] addr; logic [4:0] ini; logic [31:0] wdata; logic [3:0] be; logic rr;
      logic e_rdy; logic e_mreq; logic e_rv; logic [4:0] e_ini; logic [31:0] e_rdata;
   } vec_t;
   vec_t vecs [23];

   typedef struct { logic [4:0] ini; logic [31:0] data; int rdy; } rsp_t;
   rsp_t q [$];

   variable_latency_bank_adapter #(.MemLatency(1), .RespFifoDepth(3)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(a_vld), .req_ready_o(a_rdy), .req_ini_addr_i(a_ini),
      .req_tgt_addr_i(a_addr), .req_wen_i(a_wen), .req_wdata_i(a_wdata), .req_be_i(a_be),
      .resp_valid_o(a_rv), .resp_ready_i(a_rr), .resp_ini_addr_o(a_rini), .resp_rdata_o(a_rdata),
      .mem_req_o(a_mreq), .mem_addr_o(a_maddr), .mem_wen_o(a_mwen), .mem_wdata_o(a_mwdata),
      .mem_be_o(a_mbe), .mem_rdata_i(a_mrdata));

   variable_latency_bank_adapter #(.MemLatency(LatB), .RespFifoDepth(DepthB)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .req_valid_i(b_vld), .req_ready_o(b_rdy), .req_ini_addr_i(b_ini),
      .req_tgt_addr_i(b_addr), .req_wen_i(b_wen), .req_wdata_i(b_wdata), .req_be_i(b_be),
      .resp_valid_o(b_rv), .resp_ready_i(b_rr), .resp_ini_addr_o(b_rini), .resp_rdata_o(b_rdata),
      .mem_req_o(b_mreq), .mem_addr_o(b_maddr), .mem_wen_o(b_mwen), .mem_wdata_o(b_mwdata),
      .mem_be_o(b_mbe), .mem_rdata_i(b_mrdata));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM bank A, one-cycle read latency
   always @(posedge clk) begin
      if (a_mreq) begin
         if (a_mwen) begin
            for (int k = 0; k < 4; k++) if (a_mbe[k]) sram_a[a_maddr][8*k +: 8] = a_mwdata[8*k +: 8];
         end else begin
            a_mrdata <= sram_a[a_maddr];
         end
      end
   end

   // SRAM bank B, LatB-cycle read latency
   always @(posedge clk) begin
      if (b_mreq && b_mwen) begin
         for (int k = 0; k < 4; k++) if (b_mbe[k]) sram_b[b_maddr][8*k +: 8] = b_mwdata[8*k +: 8];
      end
      rb[0] <= (b_mreq && !b_mwen) ? sram_b[b_maddr] : 32'h0;
      for (int k = 1; k < LatB; k++) rb[k] <= rb[k-1];
   end
   assign b_mrdata = rb[LatB-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic vld, input logic wen, input logic [11:0] addr, input logic [4:0] ini,
                               input logic [31:0] wdata, input logic [3:0] be, input logic rr,
                               input logic e_rdy, input logic e_mreq, input logic e_rv,
                               input logic [4:0] e_ini, input logic [31:0] e_rdata);
      vec_t v;
      v.vld = vld; v.wen = wen; v.addr = addr; v.ini = ini; v.wdata = wdata; v.be = be; v.rr = rr;
      v.e_rdy = e_rdy; v.e_mreq = e_mreq; v.e_rv = e_rv; v.e_ini = e_ini; v.e_rdata = e_rdata;
      return v;
   endfunction

   initial begin
      n_vec = 0; n_bad = 0;
      for (int i = 0; i < 4096; i++) begin
         sram_a[i] = 32'h5000_0000 | i;
         sram_b[i] = 32'hC0DE_0000 | i;
         model_b[i] = 32'hC0DE_0000 | i;
      end
      sram_a[12'h010] = 32'hDEADBEEF; sram_a[12'h011] = 32'h11111111; sram_a[12'h012] = 32'h22222222;
      sram_a[12'h013] = 32'h33333333; sram_a[12'h014] = 32'h44444444; sram_a[12'h020] = 32'hFFFFFFFF;
      for (int k = 0; k < LatB; k++) rb[k] = 32'h0;
      a_mrdata = 32'h0;

      // single read, back-to-back reads, FIFO fill with stall, write while full, drain
      vecs[0]  = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 0,  0, 32'h0);
      vecs[1]  = mk(1, 0, 12'h010,  3, 0, 0, 1, 1, 1, 0,  0, 32'h0);
      vecs[2]  = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 0,  0, 32'h0);
      vecs[3]  = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 1,  3, 32'hDEADBEEF);
      vecs[4]  = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 0,  0, 32'h0);
      vecs[5]  = mk(1, 0, 12'h011,  4, 0, 0, 1, 1, 1, 0,  0, 32'h0);
      vecs[6]  = mk(1, 0, 12'h012,  5, 0, 0, 1, 1, 1, 0,  0, 32'h0);
      vecs[7]  = mk(1, 0, 12'h013,  6, 0, 0, 1, 1, 1, 1,  4, 32'h11111111);
      vecs[8]  = mk(1, 0, 12'h014,  7, 0, 0, 1, 1, 1, 1,  5, 32'h22222222);
      vecs[9]  = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 1,  6, 32'h33333333);
      vecs[10] = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 1,  7, 32'h44444444);
      vecs[11] = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 0,  0, 32'h0);
      vecs[12] = mk(1, 0, 12'h010,  8, 0, 0, 0, 1, 1, 0,  0, 32'h0);
      vecs[13] = mk(1, 0, 12'h011,  9, 0, 0, 0, 1, 1, 0,  0, 32'h0);
      vecs[14] = mk(1, 0, 12'h012, 10, 0, 0, 0, 1, 1, 1,  8, 32'hDEADBEEF);
      vecs[15] = mk(1, 0, 12'h013, 11, 0, 0, 0, 0, 0, 1,  8, 32'hDEADBEEF);
      vecs[16] = mk(1, 0, 12'h014, 12, 0, 0, 0, 0, 0, 1,  8, 32'hDEADBEEF);
      vecs[17] = mk(1, 1, 12'h020, 13, 32'hA5A5A5A5, 4'b0011, 0, 1, 1, 1, 8, 32'hDEADBEEF);
      vecs[18] = mk(0, 0, 12'h000,  0, 0, 0, 0, 0, 0, 1,  8, 32'hDEADBEEF);
      vecs[19] = mk(0, 0, 12'h000,  0, 0, 0, 1, 0, 0, 1,  8, 32'hDEADBEEF);
      vecs[20] = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 1,  9, 32'h11111111);
      vecs[21] = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 1, 10, 32'h22222222);
      vecs[22] = mk(0, 0, 12'h000,  0, 0, 0, 1, 1, 0, 0,  0, 32'h0);

      a_vld = 1; a_wen = 0; a_addr = 0; a_ini = 0; a_wdata = 0; a_be = 0; a_rr = 1;
      b_vld = 0; b_wen = 0; b_addr = 0; b_ini = 0; b_wdata = 0; b_be = 0; b_rr = 1;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      chk("reset a_req_ready", a_rdy, 0);
      chk("reset a_mem_req", a_mreq, 0);
      chk("reset a_resp_valid", a_rv, 0);
      chk("reset b_req_ready", b_rdy, 0);
      a_vld = 0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // table-driven directed vectors on instance A
      for (int i = 0; i < 23; i++) begin
         a_vld = vecs[i].vld; a_wen = vecs[i].wen; a_addr = vecs[i].addr; a_ini = vecs[i].ini;
         a_wdata = vecs[i].wdata; a_be = vecs[i].be; a_rr = vecs[i].rr;
         @(negedge clk);
         chk($sformatf("vec%0d req_ready", i), a_rdy, vecs[i].e_rdy);
         chk($sformatf("vec%0d mem_req", i), a_mreq, vecs[i].e_mreq);
         chk($sformatf("vec%0d resp_valid", i), a_rv, vecs[i].e_rv);
         if (vecs[i].e_rv) begin
            chk($sformatf("vec%0d resp_ini", i), a_rini, vecs[i].e_ini);
            chk($sformatf("vec%0d resp_rdata", i), a_rdata, vecs[i].e_rdata);
         end
         if (vecs[i].e_mreq) begin
            chk($sformatf("vec%0d mem_addr", i), a_maddr, vecs[i].addr);
            chk($sformatf("vec%0d mem_wen", i), a_mwen, vecs[i].wen);
            if (vecs[i].wen) begin
               chk($sformatf("vec%0d mem_wdata", i), a_mwdata, vecs[i].wdata);
               chk($sformatf("vec%0d mem_be", i), a_mbe, vecs[i].be);
            end
         end
         @(posedge clk); #1;
      end
      chk("partial write sram[020]", sram_a[12'h020], 32'hFFFFA5A5);

      // reset with two reads in flight
      a_vld = 1; a_wen = 0; a_addr = 12'h010; a_ini = 20; a_rr = 1;
      @(posedge clk); #1;
      a_addr = 12'h011; a_ini = 21;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("async rst req_ready", a_rdy, 0);
      chk("async rst mem_req", a_mreq, 0);
      chk("async rst mem_addr", a_maddr, 0);
      chk("async rst resp_valid", a_rv, 0);
      chk("async rst resp_ini", a_rini, 0);
      chk("async rst resp_rdata", a_rdata, 0);
      a_vld = 0;
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("post-rst%0d resp_valid", i), a_rv, 0);
         chk($sformatf("post-rst%0d req_ready", i), a_rdy, 1);
      end
      @(posedge clk); #1;

      // randomized traffic on instance B against a queue-based reference model
      begin
         int  cyc;
         logic exp_rdy, exp_rv, exp_fire, exp_pop;
         rsp_t r;
         cyc = 0;
         for (int n = 0; n < 10040; n++) begin
            if (n < 10000) begin
               b_vld = ($urandom_range(0, 9) < 7); b_wen = ($urandom_range(0, 3) == 0);
               b_addr = 12'($urandom_range(0, 15)); b_ini = 5'($urandom_range(0, 31));
               b_wdata = $urandom; b_be = 4'($urandom_range(0, 15)); b_rr = ($urandom_range(0, 9) < 6);
            end else begin
               b_vld = 0; b_rr = 1;
            end
            @(negedge clk);
            exp_rdy = b_wen ? 1'b1 : (q.size() < DepthB);
            exp_rv = (q.size() > 0) && (q[0].rdy <= cyc);
            exp_fire = b_vld && exp_rdy;
            exp_pop = exp_rv && b_rr;
            chk($sformatf("rnd c%0d req_ready", cyc), b_rdy, exp_rdy);
            chk($sformatf("rnd c%0d mem_req", cyc), b_mreq, exp_fire);
            chk($sformatf("rnd c%0d resp_valid", cyc), b_rv, exp_rv);
            if (exp_rv) begin
               chk($sformatf("rnd c%0d resp_ini", cyc), b_rini, q[0].ini);
               chk($sformatf("rnd c%0d resp_rdata", cyc), b_rdata, q[0].data);
            end
            @(posedge clk);
            if (exp_pop) void'(q.pop_front());
            if (exp_fire) begin
               if (b_wen) begin
                  for (int k = 0; k < 4; k++) if (b_be[k]) model_b[b_addr][8*k +: 8] = b_wdata[8*k +: 8];
               end else begin
                  r.ini = b_ini; r.data = model_b[b_addr]; r.rdy = cyc + LatB + 1;
                  q.push_back(r);
               end
            end
            cyc++;
            #1;
         end
         chk("rnd all responses drained", q.size(), 0);
         @(negedge clk);
         chk("rnd no extra response", b_rv, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/variable_latency_bank_adapter.md
Name: variable_latency_bank_adapter

Overview:
- Target-side stage placed directly downstream of the variable-latency interconnect, one instance per target port.
- Converts the interconnect's valid/ready request channel into a fixed-latency SRAM bank access.
- Captures the read data and the initiator address into a credit-protected response FIFO.
- Drives that FIFO back into the interconnect's response valid/ready channel, so bank backpressure never drops data.

Parameters:
- NumInLog2, 5, width of the initiator address tag carried with each request.
- AddrMemWidth, 12, bank word-address width.
- DataWidth, 32, data word width.
- BeWidth, DataWidth/8, byte-enable width.
- MemLatency, 1, SRAM read latency in cycles; must be >= 1, else elaboration $fatal.
- RespFifoDepth, 3, response FIFO entries; must be >= 1, else $fatal. Full read throughput requires >= MemLatency+2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid from interconnect
- req_ready_o  out  1  request ready to interconnect
- req_ini_addr_i  in  NumInLog2  initiator tag
- req_tgt_addr_i  in  AddrMemWidth  bank word address
- req_wen_i  in  1  write enable
- req_wdata_i  in  DataWidth  write data
- req_be_i  in  BeWidth  byte enable
- resp_valid_o  out  1  response valid to interconnect
- resp_ready_i  in  1  response ready from interconnect
- resp_ini_addr_o  out  NumInLog2  initiator tag of response
- resp_rdata_o  out  DataWidth  response data
- mem_req_o  out  1  SRAM access strobe
- mem_addr_o  out  AddrMemWidth  SRAM address
- mem_wen_o  out  1  SRAM write enable
- mem_wdata_o  out  DataWidth  SRAM write data
- mem_be_o  out  BeWidth  SRAM byte enable
- mem_rdata_i  in  DataWidth  SRAM read data, valid MemLatency cycles after the mem_req_o cycle

Behaviour:
- One clock domain (clk_i). Reset: asynchronous, active-low rst_ni. Reset clears the credit counter, the tag/read-flag pipeline and the FIFO pointers. All outputs are 0 during reset; req_ready_o is forced 0 while rst_ni is low.
- Credit counter cnt, range 0..RespFifoDepth. It counts reads in the MemLatency pipeline plus FIFO occupancy.
- Request acceptance:
  - Read: req_ready_o = (cnt < RespFifoDepth).
  - Write: req_ready_o = 1 (writes consume no credit).
  - req_ready_o never depends on resp_ready_i; there is no same-cycle credit reuse.
- Handshake (req_valid_i & req_ready_o):
  - mem_req_o = 1 combinationally in the same cycle.
  - mem_addr/wen/wdata/be are passthrough of the req_* inputs; mem_req_o = 0 otherwise.
- Pipeline: a MemLatency-deep shift register carries {is_read, ini_addr}. It advances every cycle; no stall is needed because credits guarantee FIFO space.
- FIFO push: when the pipeline tail has is_read = 1, {ini_addr, mem_rdata_i} is pushed into the FIFO in that cycle.
- FIFO output: registered, no bypass.
  - resp_valid_o = !empty; resp_ini_addr_o/resp_rdata_o are the head entry.
  - Pop on resp_valid_o & resp_ready_i.
  - Head data stays stable while valid and not ready.
- Latency: read accepted at cycle t gives resp_valid_o at t+MemLatency+1 (FIFO empty, ready high).
- Counter update:
  - cnt +1 on read accept.
  - cnt -1 on pop.
  - Both in the same cycle: unchanged.
- FIFO pointers wrap modulo RespFifoDepth (non-power-of-2 supported). Simultaneous push and pop when full cannot occur by construction; when empty, push and pop cannot occur in the same cycle (no bypass).
- Responses return in acceptance order.
- Reset mid-operation: in-flight reads and buffered responses are discarded; no response is emitted after reset deassertion.

Optional Feature:
- Macro: VARIABLE_LATENCY_BANK_ADAPTER_WRITE_RESP_EN.
- Defined:
  - Writes are treated like reads for credits: ready requires cnt < RespFifoDepth, and the write consumes a credit.
  - Each write produces one response with its ini_addr and resp_rdata_o = 0, at the same latency as a read.
- Undefined: writes produce no response and consume no credit.

Test Plan:
- Single read to addr 0x010, ini 3, SRAM holds 0xDEADBEEF, MemLatency=1 -> mem_req_o at t, resp_valid_o at t+2 with ini 3 and rdata 0xDEADBEEF; cnt returns to 0.
- Back-to-back reads every cycle, resp_ready_i=1, depth 3 -> req_ready_o stays 1; one response per cycle, in order.
- resp_ready_i=0, 5 reads offered -> exactly 3 accepted, req_ready_o=0 afterwards, head stable. Then resp_ready_i=1 -> 3 responses drain and req_ready_o rises the cycle after the first pop.
- Write 0xA5A5A5A5 be=4'b0011 while FIFO full -> accepted immediately and memory updated, with no response (macro undefined). With the macro defined: stalled until a pop, then one response with rdata 0.
- rst_ni pulled low with 2 reads in flight -> all outputs 0 asynchronously; after release resp_valid_o stays 0 and req_ready_o=1.
- MemLatency=3, RespFifoDepth=5, random valid/ready for 10k cycles -> scoreboard matches every response's tag and data, with no loss or duplication.
